fetch_ifid: RTL and testbench
=============================

FETCH_IFID -- requirements
Module: fetch_ifid

Interface
Parameters:
REQ-001 SHALL have parameter RESET_PC, default 14'h0000: byte address fetched first after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h00000013: bubble instruction (addi x0,x0,0).
Ports:
REQ-003 SHALL have port clk  input  1: single clock, all state updates on posedge.
REQ-004 SHALL have port rst_n  input  1: reset, synchronous and active-high despite the name.
REQ-005 SHALL have port stall_i  input  1: hazard unit hold request for the IF/ID stage.
REQ-006 SHALL have port redirect_i  input  1: taken branch, jal or jalr from EX.
REQ-007 SHALL have port redirect_addr_i  input  14: target byte address.
REQ-008 SHALL have port imem_addr_o  output  14: instruction memory address.
REQ-009 SHALL have port imem_rdata_i  input  32: memory data, valid the cycle after the address is presented.
REQ-010 SHALL have port instr_o  output  32: instruction to decode.
REQ-011 SHALL have port addr_o  output  14: byte address of instr_o.
REQ-012 SHALL have port valid_o  output  1: instr_o is a real instruction, not a bubble.
REQ-013 SHALL have port resume_i  input  1: restart after halt (used only with FETCH_HALT_EN).
REQ-014 SHALL have port halted_o  output  1: fetch halted (constant 0 without FETCH_HALT_EN).

Function
REQ-015 SHALL hold PC register pc_q and drive imem_addr_o = pc_q combinationally.
REQ-016 SHALL track the in-flight request with req_valid_q and req_pc_q (address presented last cycle).
REQ-017 SHALL, with no stall and no redirect, set pc_q <= pc_q+4 (mod 2^14, wrap 14'h3FFC->0), req_pc_q <= pc_q, req_valid_q <= 1.
REQ-018 SHALL, with no stall, load the IF/ID outputs on posedge: instr_o <= response, addr_o <= req_pc_q, valid_o <= req_valid_q; one cycle of fetch latency from imem_rdata_i to instr_o.
REQ-019 SHALL use the skid buffer as the response when it is full, else imem_rdata_i.
REQ-020 SHALL, while stall_i=1, hold instr_o/addr_o/valid_o and pc_q unchanged.
REQ-021 SHALL, on the first stall cycle with req_valid_q=1, capture imem_rdata_i and req_pc_q into a one-entry skid buffer; SHALL drain the skid on the first non-stalled cycle; no instruction lost or duplicated.
REQ-022 SHALL, on redirect_i=1, set pc_q <= {redirect_addr_i[13:2],2'b00}, clear req_valid_q and the skid, and load instr_o=NOP_INSTR, valid_o=0 the same posedge.
REQ-023 SHALL give redirect_i priority over stall_i when both are high.
REQ-024 SHALL fetch the redirect target on the following cycle; first target instruction reaches instr_o two posedges after the redirect edge.

Reset
REQ-025 SHALL, on any posedge with rst_n=1, set pc_q=RESET_PC, req_valid_q=0, skid empty, instr_o=NOP_INSTR, addr_o=0, valid_o=0, halted_o=0.
REQ-026 SHALL let reset override stall_i, redirect_i and resume_i, including mid-stall and mid-halt.

Configuration
REQ-027 SHALL, with macro FETCH_HALT_EN defined, halt on an ecall (32'h00000073) reaching instr_o: pass it with valid_o=1, then set halted_o=1, freeze pc_q, and emit NOP_INSTR with valid_o=0 until resume_i=1 or redirect_i=1.
REQ-028 SHALL clear halted_o and continue fetch from pc_q on resume_i=1; redirect_i also clears halt.
REQ-029 SHALL, without FETCH_HALT_EN, treat ecall as an ordinary instruction, tie halted_o to 0 and ignore resume_i.

Verification
REQ-030 Reset then run, memory word n = 32'h1000_0000+n -> instr_o 32'h1000_0000, 32'h1000_0001, ... on consecutive cycles, addr_o 0,4,8, valid_o=1 from second post-reset edge.
REQ-031 stall_i high 3 cycles mid-stream -> outputs frozen 3 cycles, then sequence resumes with no gap or duplicate.
REQ-032 redirect_i with addr 14'h0103 while stall_i=1 -> valid_o=0 next edge, next valid instr_o at addr_o=14'h0100.
REQ-033 RESET_PC=14'h3FF8 -> addr_o 3FF8, 3FFC, 0000.
REQ-034 FETCH_HALT_EN, ecall at 14'h0010 -> halted_o=1, valid_o=0 for 5 cycles; resume_i -> next instr_o addr_o=14'h0014. Without macro -> no halt.

Source files
------------

// File: rtl/fetch_ifid.sv
// IF stage plus IF/ID pipeline register with a one-entry skid buffer for stalls.
// Optional ecall halt/resume logic is enabled by defining FETCH_HALT_EN.
module fetch_ifid #(
  parameter logic [13:0] RESET_PC  = 14'h0000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [13:0] redirect_addr_i,
  output logic [13:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [13:0] addr_o,
  output logic        valid_o,
  input  logic        resume_i,
  output logic        halted_o
);
  localparam logic [31:0] ECALL = 32'h00000073;

  logic [13:0] pc_q, req_pc_q, skid_pc_q;
  logic        req_valid_q, skid_valid_q, halted_q;
  logic [31:0] skid_data_q;

  logic [31:0] resp_data;
  logic [13:0] resp_pc;
  logic        resp_valid;
  logic        halt_hit, halt_hold;

  assign imem_addr_o = pc_q;
  assign halted_o    = halted_q;

  // A full skid always predates the current memory word, so it drains first.
  always_comb begin
    resp_data  = skid_valid_q ? skid_data_q : imem_rdata_i;
    resp_pc    = skid_valid_q ? skid_pc_q   : req_pc_q;
    resp_valid = skid_valid_q | req_valid_q;
  end

`ifdef FETCH_HALT_EN
  always_comb begin
    halt_hit  = valid_o && (instr_o == ECALL);
    halt_hold = halted_q && !resume_i;
  end
`else
  logic unused_resume;
  assign unused_resume = resume_i;
  always_comb begin
    halt_hit  = 1'b0;
    halt_hold = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst_n) begin
      pc_q         <= RESET_PC;
      req_pc_q     <= 14'h0000;
      req_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= 14'h0000;
      skid_data_q  <= 32'h0;
      instr_o      <= NOP_INSTR;
      addr_o       <= 14'h0000;
      valid_o      <= 1'b0;
      halted_q     <= 1'b0;
    end else if (redirect_i) begin
      pc_q         <= {redirect_addr_i[13:2], 2'b00};
      req_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      instr_o      <= NOP_INSTR;
      valid_o      <= 1'b0;
      halted_q     <= 1'b0;
    end else if (halt_hold) begin
      halted_q <= 1'b1;
    end else if (stall_i) begin
      halted_q <= 1'b0;
      if (req_valid_q && !skid_valid_q) begin
        skid_valid_q <= 1'b1;
        skid_data_q  <= imem_rdata_i;
        skid_pc_q    <= req_pc_q;
      end
    end else if (halt_hit) begin
      // Drop in-flight work; resume refetches the word after the ecall.
      halted_q     <= 1'b1;
      pc_q         <= addr_o + 14'd4;
      req_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      instr_o      <= NOP_INSTR;
      valid_o      <= 1'b0;
    end else begin
      halted_q     <= 1'b0;
      pc_q         <= pc_q + 14'd4;
      req_pc_q     <= pc_q;
      req_valid_q  <= 1'b1;
      skid_valid_q <= 1'b0;
      instr_o      <= resp_valid ? resp_data : NOP_INSTR;
      addr_o       <= resp_pc;
      valid_o      <= resp_valid;
    end
  end
endmodule

// File: tb/tb_fetch_ifid.sv
// Randomized bench for fetch_ifid against an instruction-stream reference model.
module tb_fetch_ifid;
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [31:0] ECALL = 32'h00000073;
`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, stall = 1'b0, redir = 1'b0, resume = 1'b0;
  logic [13:0] raddr = 14'h0;
  logic [13:0] imem_addr, addr, imem_addr_w, addr_w;
  logic [31:0] rdata = 32'h0, rdata_w = 32'h0, instr, instr_w;
  logic        valid, halted, valid_w, halted_w;
  logic        ecall_on = 1'b0;

  int total = 0, bad = 0;

  fetch_ifid u_dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .redirect_i(redir),
    .redirect_addr_i(raddr), .imem_addr_o(imem_addr), .imem_rdata_i(rdata),
    .instr_o(instr), .addr_o(addr), .valid_o(valid), .resume_i(resume),
    .halted_o(halted)
  );

  fetch_ifid #(.RESET_PC(14'h3FF8)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .redirect_i(redir),
    .redirect_addr_i(raddr), .imem_addr_o(imem_addr_w), .imem_rdata_i(rdata_w),
    .instr_o(instr_w), .addr_o(addr_w), .valid_o(valid_w), .resume_i(resume),
    .halted_o(halted_w)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [13:0] a);
    if (ecall_on && a == 14'h0010) return ECALL;
    return 32'h1000_0000 + {20'h0, a[13:2]};
  endfunction

  always @(posedge clk) begin
    rdata   <= mem_word(imem_addr);
    rdata_w <= mem_word(imem_addr_w);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: the decode side sees a stream of consecutive words from the
  // last reset/redirect/resume point; one bubble edge precedes the stream.
  logic [31:0] m_instr = NOP;
  logic [13:0] m_addr = 14'h0, exp_addr = 14'h0;
  logic        m_valid = 1'b0, m_halt = 1'b0, warm = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
    if (rst_n) begin
      m_instr = NOP; m_addr = 14'h0; m_valid = 1'b0; m_halt = 1'b0;
      warm = 1'b0; exp_addr = 14'h0000;
    end else if (redir) begin
      m_instr = NOP; m_valid = 1'b0; m_halt = 1'b0; warm = 1'b0;
      exp_addr = raddr & 14'h3FFC;
    end else if (HALT_EN && m_halt && !resume) begin
      // frozen
    end else begin
      m_halt = 1'b0;
      if (stall) begin
        // outputs held
      end else if (HALT_EN && m_valid && m_instr == ECALL) begin
        m_halt = 1'b1; m_valid = 1'b0; m_instr = NOP; warm = 1'b0;
        exp_addr = m_addr + 14'd4;
      end else if (warm) begin
        m_valid = 1'b1; m_addr = exp_addr; m_instr = mem_word(exp_addr);
        exp_addr = exp_addr + 14'd4;
      end else begin
        m_valid = 1'b0; m_instr = NOP; warm = 1'b1;
      end
    end
    chk("valid", {31'h0, valid}, {31'h0, m_valid});
    chk("instr", instr, m_instr);
    chk("halted", {31'h0, halted}, {31'h0, m_halt});
    if (m_valid) chk("addr", {18'h0, addr}, {18'h0, m_addr});
  endtask

  initial begin
    rst_n = 1'b1;
    step();
    chk("rst_addr", {18'h0, addr}, 32'h0);
    chk("rst_w_valid", {31'h0, valid_w}, 32'h0);
    rst_n = 1'b0;

    // straight-line fetch, plus wrap on the 3FF8 instance
    step();
    step();
    chk("first_instr", instr, 32'h1000_0000);
    chk("w_a0", {18'h0, addr_w}, 32'h3FF8);
    step();
    chk("w_a1", {18'h0, addr_w}, 32'h3FFC);
    step();
    chk("w_a2", {18'h0, addr_w}, 32'h0000);
    chk("w_v2", {31'h0, valid_w}, 32'h1);
    repeat (3) step();

    // three-cycle stall mid-stream
    stall = 1'b1;
    repeat (3) step();
    stall = 1'b0;
    repeat (4) step();

    // redirect wins over stall
    stall = 1'b1; redir = 1'b1; raddr = 14'h0103;
    step();
    chk("redir_bubble", {31'h0, valid}, 32'h0);
    redir = 1'b0;
    step();
    stall = 1'b0;
    repeat (2) step();
    chk("redir_tgt", {18'h0, addr}, 32'h0100);
    repeat (2) step();

    // ecall at 0x0010
    ecall_on = 1'b1;
    redir = 1'b1; raddr = 14'h0008;
    step();
    redir = 1'b0;
    repeat (10) step();
    resume = 1'b1;
    step();
    resume = 1'b0;
    repeat (4) step();

    // reset mid-stall
    stall = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    rst_n = 1'b0; stall = 1'b0;
    repeat (4) step();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      stall  = ($urandom % 4) == 0;
      redir  = ($urandom % 16) == 0;
      resume = ($urandom % 6) == 0;
      rst_n  = ($urandom % 150) == 0;
      case ($urandom % 3)
        0: raddr = 14'h0008;
        1: raddr = 14'h0003;
        default: raddr = 14'($urandom);
      endcase
      step();
    end
    rst_n = 1'b0; stall = 1'b0; redir = 1'b0; resume = 1'b0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
